// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the 4x4 multiplier control FSM.
// State encoding, shift codes and the per-state half-select table.
package mult_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SH_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    P0   = 3'd2,
    P1   = 3'd3,
    P2   = 3'd4,
    P3   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [SH_W-1:0] SH_0 = 2'b00;
  localparam logic [SH_W-1:0] SH_2 = 2'b01;
  localparam logic [SH_W-1:0] SH_4 = 2'b10;

  typedef struct packed {
    logic            l_1;
    logic            l_2;
    logic [SH_W-1:0] sh;
  } half_sel_t;

  // Operand halves and shift for each partial-product state; zero elsewhere.
  function automatic half_sel_t half_sel(input state_t s);
    half_sel_t r;
    r = '0;
    case (s)
      P0:      r = half_sel_t'{1'b0, 1'b0, SH_0};
      P1:      r = half_sel_t'{1'b1, 1'b0, SH_2};
      P2:      r = half_sel_t'{1'b0, 1'b1, SH_2};
      P3:      r = half_sel_t'{1'b1, 1'b1, SH_4};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mult_ctrl_settle_cnt.sv
// Per-partial-product settle counter; tc flags the last cycle of a Pn state.
// With SETTLE_CYCLES=0 the count never leaves zero, so tc is always 1.
module mult_ctrl_settle_cnt #(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(SETTLE_CYCLES));

endmodule

// File: rtl/mult_4x4_controller.sv
// Control FSM sequencing four 2x2 partial products into the 8-bit accumulator.
// Optional `MULT_CTRL_HANDSHAKE_EN adds an ack input that holds done until acknowledged.
module mult_4x4_controller
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef MULT_CTRL_HANDSHAKE_EN
  input  logic ack,
`endif
  output logic ld_A,
  output logic ld_B,
  output logic l_1,
  output logic l_2,
  output logic shctrl_1,
  output logic shctrl_0,
  output logic rst_out,
  output logic ld_out,
  output logic busy,
  output logic done
);

  state_t    state, state_nxt;
  half_sel_t hs;
  logic      tc, cnt_clr, cnt_en;

  mult_ctrl_settle_cnt #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Moore outputs; the counter is cleared everywhere except while settling inside a Pn.
  always_comb begin
    state_nxt = state;
    hs        = '0;
    ld_A      = 1'b0;
    ld_B      = 1'b0;
    rst_out   = 1'b0;
    ld_out    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        ld_A      = 1'b1;
        ld_B      = 1'b1;
        rst_out   = 1'b1;
        busy      = 1'b1;
        state_nxt = P0;
      end
      P0, P1, P2, P3: begin
        busy    = 1'b1;
        hs      = half_sel(state);
        cnt_en  = 1'b1;
        cnt_clr = 1'b0;
        if (tc) begin
          ld_out  = 1'b1;
          cnt_clr = 1'b1;
          case (state)
            P0:      state_nxt = P1;
            P1:      state_nxt = P2;
            P2:      state_nxt = P3;
            default: state_nxt = DONE;
          endcase
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
`ifdef MULT_CTRL_HANDSHAKE_EN
        if (ack) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign l_1      = hs.l_1;
  assign l_2      = hs.l_2;
  assign shctrl_1 = hs.sh[1];
  assign shctrl_0 = hs.sh[0];

endmodule

// File: tb/tb_mult_4x4_controller.sv
// Bench for mult_4x4_controller: two instances (SETTLE_CYCLES 0 and 2) driving a behavioural datapath.
module tb_mult_4x4_controller;

  logic clk = 1'b0;
  logic rst;
  logic start_v [2];
  logic ack_v   [2];
  logic [3:0] a_in [2];
  logic [3:0] b_in [2];

  logic ld_a0, ld_b0, l1_0, l2_0, sh1_0, sh0_0, ro_0, lo_0, busy_0, done_0;
  logic ld_a1, ld_b1, l1_1, l2_1, sh1_1, sh0_1, ro_1, lo_1, busy_1, done_1;
  logic [9:0] obs [2];

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  mult_4x4_controller #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
`ifdef MULT_CTRL_HANDSHAKE_EN
    .ack(ack_v[0]),
`endif
    .ld_A(ld_a0), .ld_B(ld_b0), .l_1(l1_0), .l_2(l2_0), .shctrl_1(sh1_0), .shctrl_0(sh0_0),
    .rst_out(ro_0), .ld_out(lo_0), .busy(busy_0), .done(done_0)
  );

  mult_4x4_controller #(.SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]),
`ifdef MULT_CTRL_HANDSHAKE_EN
    .ack(ack_v[1]),
`endif
    .ld_A(ld_a1), .ld_B(ld_b1), .l_1(l1_1), .l_2(l2_1), .shctrl_1(sh1_1), .shctrl_0(sh0_1),
    .rst_out(ro_1), .ld_out(lo_1), .busy(busy_1), .done(done_1)
  );

  assign obs[0] = {ld_a0, ld_b0, l1_0, l2_0, sh1_0, sh0_0, ro_0, lo_0, busy_0, done_0};
  assign obs[1] = {ld_a1, ld_b1, l1_1, l2_1, sh1_1, sh0_1, ro_1, lo_1, busy_1, done_1};

  // Behavioural datapath: operand registers plus shift-accumulate of 2x2 products.
  logic [3:0] ra  [2];
  logic [3:0] rb  [2];
  logic [7:0] acc [2];

  function automatic logic [7:0] part(input logic [3:0] a, input logic [3:0] b,
                                      input logic h1, input logic h2, input logic [1:0] sh);
    int pa, pb;
    pa = h1 ? int'(a[3:2]) : int'(a[1:0]);
    pb = h2 ? int'(b[3:2]) : int'(b[1:0]);
    return 8'((pa * pb) << (2 * int'(sh)));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (obs[k][9]) ra[k] <= a_in[k];
      if (obs[k][8]) rb[k] <= b_in[k];
      if (obs[k][3]) acc[k] <= 8'h00;
      else if (obs[k][2]) acc[k] <= acc[k] + part(ra[k], rb[k], obs[k][7], obs[k][6], obs[k][5:4]);
    end
  end

  function automatic logic [9:0] vec(input bit la, input bit lb, input bit h1, input bit h2,
                                     input bit [1:0] sh, input bit ro, input bit lo,
                                     input bit bu, input bit dn);
    return {la, lb, h1, h2, sh, ro, lo, bu, dn};
  endfunction

  // Expected control trace from LOAD through DONE for a given settle count.
  task automatic build_exp(input int s);
    bit       hl1 [4];
    bit       hl2 [4];
    bit [1:0] shc [4];
    hl1 = '{1'b0, 1'b1, 1'b0, 1'b1};
    hl2 = '{1'b0, 1'b0, 1'b1, 1'b1};
    shc = '{2'd0, 2'd1, 2'd1, 2'd2};
    exp_q.delete();
    exp_q.push_back(vec(1, 1, 0, 0, 2'd0, 1, 0, 1, 0));
    for (int p = 0; p < 4; p++)
      for (int c = 0; c <= s; c++)
        exp_q.push_back(vec(0, 0, hl1[p], hl2[p], shc[p], 0, (c == s), 1, 0));
    exp_q.push_back(vec(0, 0, 0, 0, 2'd0, 0, 0, 1, 1));
  endtask

  task automatic drain(input int idx);
    bit seen = 0;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      if (obs[idx][0]) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL drain_done dut%0d: no done within budget, got ctl=%b", idx, obs[idx]);
    end
    ack_v[idx] = 1'b1;
    @(negedge clk);
    ack_v[idx] = 1'b0;
  endtask

  task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                        input bit inject, input bit hold);
    int s, p1i;
    logic [7:0] want;
    s    = (idx == 0) ? 0 : 2;
    p1i  = 1 + (s + 1);
    want = 8'(int'(a) * int'(b));
    build_exp(s);
    a_in[idx] = a;
    b_in[idx] = b;
    @(negedge clk);
    start_v[idx] = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start_v[idx] = hold || (inject && i == p1i);
      total++;
      if (obs[idx] !== exp_q[i]) begin
        bad++;
        $display("FAIL trace dut%0d a=%h b=%h cyc=%0d: got %b want %b", idx, a, b, i, obs[idx], exp_q[i]);
      end
    end
    total++;
    if (acc[idx] !== want) begin
      bad++;
      $display("FAIL product dut%0d %h*%h: got %h want %h", idx, a, b, acc[idx], want);
    end
`ifdef MULT_CTRL_HANDSHAKE_EN
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      total++;
      if (obs[idx] !== exp_q[exp_q.size()-1]) begin
        bad++;
        $display("FAIL done_hold dut%0d wait=%0d: got %b want %b", idx, j, obs[idx], exp_q[exp_q.size()-1]);
      end
    end
    ack_v[idx] = 1'b1;
`endif
    @(negedge clk);
    ack_v[idx] = 1'b0;
    total++;
    if (obs[idx] !== 10'b0) begin
      bad++;
      $display("FAIL return_idle dut%0d: got %b want %b", idx, obs[idx], 10'b0);
    end
    if (hold) begin
      @(negedge clk);
      start_v[idx] = 1'b0;
      total++;
      if (obs[idx] !== exp_q[0]) begin
        bad++;
        $display("FAIL restart_load dut%0d: got %b want %b", idx, obs[idx], exp_q[0]);
      end
      drain(idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== 10'b0) begin
          bad++;
          $display("FAIL reset dut%0d cyc=%0d: got %b want %b", k, c, obs[k], 10'b0);
        end
      end
    end
    rst = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== 10'b0) begin
        bad++;
        $display("FAIL post_reset dut%0d: got %b want %b", k, obs[k], 10'b0);
      end
    end
  endtask

  task automatic test_sequence();
    run_op(0, 4'hF, 4'hF, 0, 0);
    run_op(0, 4'h9, 4'h6, 0, 0);
    run_op(0, 4'h0, 4'hD, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_op(0, 4'hB, 4'h5, 1, 0);
    @(negedge clk);
    total++;
    if (obs[0] !== 10'b0) begin
      bad++;
      $display("FAIL no_second_op: got %b want %b", obs[0], 10'b0);
    end
  endtask

  task automatic test_mid_reset();
    build_exp(0);
    a_in[0] = 4'hE;
    b_in[0] = 4'hA;
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    total++;
    if (obs[0] !== exp_q[3]) begin
      bad++;
      $display("FAIL pre_reset_p2: got %b want %b", obs[0], exp_q[3]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (obs[0] !== 10'b0) begin
      bad++;
      $display("FAIL mid_reset: got %b want %b", obs[0], 10'b0);
    end
    run_op(0, 4'h7, 4'h3, 0, 0);
  endtask

  task automatic test_settle();
    run_op(1, 4'hF, 4'hF, 0, 0);
    run_op(1, 4'h7, 4'h3, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_op(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 0);
      run_op(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    run_op(0, 4'hC, 4'h6, 0, 1);
    run_op(1, 4'h5, 4'hA, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0;
      ack_v[k]   = 1'b0;
      a_in[k]    = 4'h0;
      b_in[k]    = 4'h0;
    end
    test_reset();
    test_sequence();
    test_start_while_busy();
    test_mid_reset();
    test_settle();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
